onchip_mem_fill_check_master: RTL and testbench

//  Avalon-MM master driving the s1 port of the 32-bit single-port on-chip RAM (13-bit word addr, 8000 words).
//  On start it fills a word range with a deterministic pattern, then reads it back and compares.
//  It reports pass/fail, the error count and the first failing address.

---
 rtl/onchip_mem_fill_check_master.sv | 135 +++++++++++++
 tb/tb_onchip_mem_fill_check_master.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_fill_check_master.sv
// Memory BIST master: fills a word range with an additive pattern, reads it back, counts mismatches.
// Latency 2*count+2 cycles (fill+verify) or count+2 (verify only); no backpressure, target has fixed read latency 1.
module onchip_mem_fill_check_master #(
    parameter int                ADDR_W = 13,
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 8000,
    parameter logic [DATA_W-1:0] STEP   = 32'h9E3779B9
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                mode,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     count,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                cfg_err,
    output logic [ADDR_W:0]     err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    input  logic [DATA_W-1:0]   m_readdata,
    output logic                m_clken
);

    localparam int CW = ADDR_W + 2;

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr, base;
    logic [ADDR_W:0]     idx, cnt_m1;
    logic [DATA_W-1:0]   pat, seed_q, exp_dat;
    logic [ADDR_W-1:0]   exp_addr;
    logic                rd_vld;
    logic [CW-1:0]       end_addr;
    logic                range_bad;
    logic                last;

    // Extra headroom bit so base+count can never wrap before the DEPTH compare.
    assign end_addr  = CW'(base_addr) + CW'(count);
    assign range_bad = (count == '0) || (end_addr > CW'(DEPTH));
    assign last      = (idx == cnt_m1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = range_bad ? DONE : (mode ? READ : WRITE);
            WRITE:   if (last) state_nxt = READ;
            READ:    if (last) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr           <= '0;
            base           <= '0;
            idx            <= '0;
            cnt_m1         <= '0;
            pat            <= '0;
            seed_q         <= '0;
            exp_dat        <= '0;
            exp_addr       <= '0;
            rd_vld         <= 1'b0;
            pass           <= 1'b0;
            cfg_err        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            rd_vld   <= (state == READ);
            exp_dat  <= pat;
            exp_addr <= addr;
            case (state)
                IDLE: if (start) begin
                    pass           <= 1'b0;
                    cfg_err        <= range_bad;
                    err_count      <= '0;
                    first_err_addr <= '0;
                    addr           <= base_addr;
                    base           <= base_addr;
                    pat            <= seed;
                    seed_q         <= seed;
                    idx            <= '0;
                    cnt_m1         <= count - 1'b1;
                end
                WRITE: begin
                    // Rewind address and pattern for the verify pass.
                    if (last) begin
                        addr <= base;
                        pat  <= seed_q;
                        idx  <= '0;
                    end else begin
                        addr <= addr + 1'b1;
                        pat  <= pat + STEP;
                        idx  <= idx + 1'b1;
                    end
                end
                READ: begin
                    addr <= addr + 1'b1;
                    pat  <= pat + STEP;
                    idx  <= idx + 1'b1;
                end
                DONE:    pass <= (err_count == '0) && !cfg_err;
                default: ;
            endcase
            if (rd_vld && (m_readdata != exp_dat)) begin
                err_count <= err_count + 1'b1;
                if (err_count == '0) first_err_addr <= exp_addr;
            end
        end
    end

    assign busy         = (state == WRITE) || (state == READ) || (state == DRAIN);
    assign done         = (state == DONE);
    assign m_address    = addr;
    assign m_writedata  = pat;
    assign m_chipselect = (state == WRITE) || (state == READ);
    assign m_write      = (state == WRITE);
    assign m_byteenable = '1;
    assign m_clken      = reset_n;

endmodule

// File: tb/tb_onchip_mem_fill_check_master.sv
// Directed bench: on-chip RAM model with optional write corruption, table of runs plus reset/start corner cases.
module tb_onchip_mem_fill_check_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [12:0] base_addr = '0;
    logic [13:0] count = '0;
    logic [31:0] seed = '0;
    logic        busy, done, pass, cfg_err;
    logic [13:0] err_count;
    logic [12:0] first_err_addr, m_address;
    logic [3:0]  m_byteenable;
    logic        m_chipselect, m_write, m_clken;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = '0;

    onchip_mem_fill_check_master dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .base_addr(base_addr), .count(count), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .cfg_err(cfg_err),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .m_address(m_address), .m_byteenable(m_byteenable),
        .m_chipselect(m_chipselect), .m_write(m_write),
        .m_writedata(m_writedata), .m_readdata(m_readdata), .m_clken(m_clken)
    );

    always #5 clk = ~clk;

    // RAM model; writes to corr_a/corr_b store the inverted word.
    logic [31:0] mem [0:8191];
    int corr_a = -1;
    int corr_b = -1;
    always @(posedge clk) begin
        if (m_chipselect) begin
            if (m_write)
                mem[m_address] <= (int'(m_address) == corr_a || int'(m_address) == corr_b)
                                  ? ~m_writedata : m_writedata;
            m_readdata <= mem[m_address];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one start and watches the run until done (bounded).
    task automatic run(input logic md, input logic [12:0] b, input logic [13:0] n,
                       input logic [31:0] s, input int pulse_at,
                       output int done_cyc, output int cs_cnt, output int last_wa,
                       output logic busy_c1);
        int c;
        @(negedge clk);
        mode = md; base_addr = b; count = n; seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1; done_cyc = -1; cs_cnt = 0; last_wa = -1; busy_c1 = 1'b0;
        while (c < 20000 && done_cyc < 0) begin
            if (c == 1) busy_c1 = busy;
            if (m_chipselect) cs_cnt++;
            if (m_chipselect && m_write) last_wa = int'(m_address);
            if (done) done_cyc = c;
            start = (c == pulse_at);
            @(negedge clk);
            c++;
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic        md;
        logic [12:0] b;
        logic [13:0] n;
        logic [31:0] s;
        int          ca, cb;
        int          e_done;
        logic        e_pass, e_cfg, e_busy;
        int          e_err, e_first, e_cs, e_lwa;
    } vec_t;

    vec_t vt [11];
    int dc, cs, lwa, sd;
    logic b1, seen_done;

    initial begin
        //        md    base   cnt    seed          ca  cb  done  pass cfg busy err first cs    lwa
        vt[0]  = '{1'b0, 13'd0,    14'd16,   32'h0,        -1, -1, 34,   1, 0, 1, 0, 0, 32,    15};
        vt[1]  = '{1'b0, 13'd0,    14'd16,   32'h0,         5, -1, 34,   0, 0, 1, 1, 5, 32,    15};
        vt[2]  = '{1'b0, 13'd0,    14'd16,   32'h0,         3,  9, 34,   0, 0, 1, 2, 3, 32,    15};
        vt[3]  = '{1'b1, 13'd0,    14'd16,   32'h0,        -1, -1, 18,   0, 0, 1, 2, 3, 16,    -1};
        vt[4]  = '{1'b0, 13'd100,  14'd1,    32'h12345678, -1, -1, 4,    1, 0, 1, 0, 0, 2,     100};
        vt[5]  = '{1'b0, 13'd7990, 14'd20,   32'h0,        -1, -1, 1,    0, 1, 0, 0, 0, 0,     -1};
        vt[6]  = '{1'b0, 13'd0,    14'd0,    32'h0,        -1, -1, 1,    0, 1, 0, 0, 0, 0,     -1};
        vt[7]  = '{1'b0, 13'd7999, 14'd1,    32'hA5A5A5A5, -1, -1, 4,    1, 0, 1, 0, 0, 2,     7999};
        vt[8]  = '{1'b0, 13'd7999, 14'd2,    32'h0,        -1, -1, 1,    0, 1, 0, 0, 0, 0,     -1};
        vt[9]  = '{1'b1, 13'd100,  14'd1,    32'h12345678, -1, -1, 3,    1, 0, 1, 0, 0, 1,     -1};
        vt[10] = '{1'b0, 13'd0,    14'd8000, 32'hFFFFFFFF, -1, -1, 16002, 1, 0, 1, 0, 0, 16000, 7999};

        // Reset state
        #1;
        chk("rst_clken", m_clken, 0);
        chk("rst_be", m_byteenable, 4'hF);
        chk("rst_cs", m_chipselect, 0);
        chk("rst_busy_done", {busy, done, pass, cfg_err}, 0);
        chk("rst_errs", {err_count, first_err_addr}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1 chk("clken_on", m_clken, 1);

        // Start re-pulsed mid-run is ignored
        run(1'b0, 13'd0, 14'd16, 32'h0, 5, dc, cs, lwa, b1);
        chk("pulse_done_cyc", dc, 34);
        chk("pulse_pass", pass, 1);
        chk("pulse_cs", cs, 32);
        chk("pat_word1", mem[1], 32'h9E3779B9);
        chk("pat_word0", mem[0], 32'h0);

        for (int i = 0; i < 11; i++) begin
            corr_a = vt[i].ca; corr_b = vt[i].cb;
            run(vt[i].md, vt[i].b, vt[i].n, vt[i].s, -1, dc, cs, lwa, b1);
            corr_a = -1; corr_b = -1;
            chk($sformatf("v%0d_done_cyc", i), dc, vt[i].e_done);
            chk($sformatf("v%0d_pass", i), pass, vt[i].e_pass);
            chk($sformatf("v%0d_cfg_err", i), cfg_err, vt[i].e_cfg);
            chk($sformatf("v%0d_busy_c1", i), b1, vt[i].e_busy);
            chk($sformatf("v%0d_err_count", i), err_count, vt[i].e_err);
            chk($sformatf("v%0d_first_err", i), first_err_addr, vt[i].e_first);
            chk($sformatf("v%0d_cs_cycles", i), cs, vt[i].e_cs);
            chk($sformatf("v%0d_last_waddr", i), lwa, vt[i].e_lwa);
        end
        chk("wrap_word1", mem[1], 32'h9E3779B8);

        // Reset asserted mid-run at cycle 10
        @(negedge clk);
        mode = 1'b0; base_addr = 13'd0; count = 14'd16; seed = 32'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 10; c++) @(negedge clk);
        chk("mid_cs_before", m_chipselect, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_cs_drop", {m_chipselect, m_write}, 0);
        chk("mid_busy_clken", {busy, m_clken}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        seen_done = 1'b0;
        sd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            if (m_chipselect) sd++;
        end
        chk("mid_no_done", seen_done, 0);
        chk("mid_no_cs", sd, 0);
        chk("mid_results_clr", {pass, err_count, first_err_addr}, 0);
        run(1'b0, 13'd0, 14'd16, 32'h0, -1, dc, cs, lwa, b1);
        chk("restart_done_cyc", dc, 34);
        chk("restart_pass", pass, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
